// File: rtl/dmro_serial_framer.sv
// Serial frame builder in the bit-clock domain: header + payload words, optional
// multiplicative scrambling, payload bit reversal, idle insertion and a PRBS7 test mode.
module dmro_serial_framer #(
  parameter int                         DATA_WIDTH   = 30,
  parameter int                         HEADER_WIDTH = 2,
  parameter logic [HEADER_WIDTH-1:0]    DATA_HEADER  = 2'b10,
  parameter logic [HEADER_WIDTH-1:0]    IDLE_HEADER  = 2'b01,
  parameter logic [DATA_WIDTH-1:0]      IDLE_PATTERN = '0,
  parameter int                         CNT_WIDTH    = 16
) (
  input  logic                  CLKBit,
  input  logic                  RSTn,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  DataValid,
  output logic                  DataReady,
  input  logic                  REVData,
  input  logic                  ENScr,
  input  logic                  TestMode,
  output logic                  DataOut,
  output logic                  FrameStart,
  output logic [CNT_WIDTH-1:0]  DataFrameCnt,
  output logic [CNT_WIDTH-1:0]  IdleFrameCnt
);

  localparam int W  = HEADER_WIDTH + DATA_WIDTH;
  localparam int BW = $clog2(W);

  logic [BW-1:0]         bit_cnt;
  logic [W-2:0]          shift_q;
  logic [57:0]           scr_q;
  logic [6:0]            prbs_q;
  logic                  mode_test;
  logic                  mode_scr;

  logic                  load;
  logic [DATA_WIDTH-1:0] rev_word;
  logic [DATA_WIDTH-1:0] payload;
  logic [W-1:0]          frame;
  logic                  prbs_bit;
  logic                  raw_bit;
  logic                  scr_bit;
  logic                  in_payload;

  assign load      = (bit_cnt == BW'(W-1));
  assign DataReady = load;

  always_comb begin
    rev_word = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      rev_word[i] = DataIn[DATA_WIDTH-1-i];
    end
  end

  assign payload    = REVData ? rev_word : DataIn;
  assign frame      = DataValid ? {DATA_HEADER, payload} : {IDLE_HEADER, IDLE_PATTERN};
  assign prbs_bit   = prbs_q[6] ^ prbs_q[5];
  assign raw_bit    = shift_q[W-2];
  assign scr_bit    = raw_bit ^ scr_q[38] ^ scr_q[57];
  // The edge with BitCnt==b drives frame bit b+1, so payload starts at b==HEADER_WIDTH-1.
  assign in_payload = (bit_cnt >= BW'(HEADER_WIDTH-1));

  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      scr_q        <= '0;
      prbs_q       <= '1;
      mode_test    <= 1'b0;
      mode_scr     <= 1'b0;
      DataOut      <= 1'b0;
      FrameStart   <= 1'b0;
      DataFrameCnt <= '0;
      IdleFrameCnt <= '0;
    end else begin
      bit_cnt <= load ? '0 : bit_cnt + 1'b1;
      if (load) begin
        mode_test  <= TestMode;
        mode_scr   <= ENScr;
        shift_q    <= frame[W-2:0];
        FrameStart <= 1'b1;
        // The newly sampled mode already governs the first bit of this frame.
        if (TestMode) begin
          DataOut <= prbs_bit;
          prbs_q  <= {prbs_q[5:0], prbs_bit};
        end else begin
          DataOut <= frame[W-1];
          if (DataValid) DataFrameCnt <= DataFrameCnt + 1'b1;
          else           IdleFrameCnt <= IdleFrameCnt + 1'b1;
        end
      end else begin
        shift_q    <= {shift_q[W-3:0], 1'b0};
        FrameStart <= 1'b0;
        if (mode_test) begin
          DataOut <= prbs_bit;
          prbs_q  <= {prbs_q[5:0], prbs_bit};
        end else if (mode_scr && in_payload) begin
          DataOut <= scr_bit;
          scr_q   <= {scr_q[56:0], scr_bit};
        end else begin
          DataOut <= raw_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmro_serial_framer.sv
// Directed bench for dmro_serial_framer: frame contents, idle insertion, scrambling,
// PRBS7 test mode, mode switching at frame boundaries and asynchronous reset.
module tb_dmro_serial_framer;

  localparam int DW = 30;
  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk;
  logic          rstn;
  logic [DW-1:0] DataIn;
  logic          DataValid;
  logic          DataReady;
  logic          REVData;
  logic          ENScr;
  logic          TestMode;
  logic          DataOut;
  logic          FrameStart;
  logic [CW-1:0] DataFrameCnt;
  logic [CW-1:0] IdleFrameCnt;

  int n_checks = 0;
  int n_pass   = 0;

  dmro_serial_framer #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .CLKBit      (clk),
    .RSTn        (rstn),
    .DataIn      (DataIn),
    .DataValid   (DataValid),
    .DataReady   (DataReady),
    .REVData     (REVData),
    .ENScr       (ENScr),
    .TestMode    (TestMode),
    .DataOut     (DataOut),
    .FrameStart  (FrameStart),
    .DataFrameCnt(DataFrameCnt),
    .IdleFrameCnt(IdleFrameCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reset, then count edges until the first load cycle while watching DataOut.
  task automatic do_reset(input logic tm, input string tag);
    int   n;
    logic any_out;
    @(negedge clk);
    rstn = 1'b0; TestMode = tm; DataValid = 1'b0; DataIn = '0; REVData = 1'b0; ENScr = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n = 0; any_out = 1'b0;
    while (!DataReady && n < 100) begin
      @(posedge clk); @(negedge clk);
      any_out |= DataOut;
      n++;
    end
    check_eq({tag, "_first_ready"}, n, 31);
    check_eq({tag, "_quiet_before_load"}, any_out, 0);
  endtask

  task automatic send(input logic v, input logic [DW-1:0] d, input logic rev,
                      input logic scr, input logic tm);
    int n = 0;
    while (!DataReady && n < 2*W) begin
      @(negedge clk);
      n++;
    end
    if (!DataReady) check_eq("ready_timeout", 0, 1);
    DataValid = v; DataIn = d; REVData = rev; ENScr = scr; TestMode = tm;
  endtask

  // Capture one frame MSB-first; optionally flip TestMode after bit flip_at.
  task automatic grab(input int flip_at, output logic [W-1:0] bits, output logic [W-1:0] fs);
    for (int i = 0; i < W; i++) begin
      @(posedge clk); @(negedge clk);
      bits[W-1-i] = DataOut;
      fs[W-1-i]   = FrameStart;
      if (i == flip_at) TestMode = ~TestMode;
    end
  endtask

  task automatic prbs_frame(inout logic [6:0] p, output logic [W-1:0] v);
    logic b;
    for (int i = 0; i < W; i++) begin
      b = p[6] ^ p[5];
      v[W-1-i] = b;
      p = {p[5:0], b};
    end
  endtask

  task automatic descramble(input logic [W-1:0] fr, inout logic [57:0] ds, output logic [DW-1:0] pl);
    logic r;
    for (int i = DW-1; i >= 0; i--) begin
      r = fr[i];
      pl[i] = r ^ ds[38] ^ ds[57];
      ds = {ds[56:0], r};
    end
  endtask

  initial begin
    logic [W-1:0]  fr, fs, ex;
    logic [DW-1:0] pl;
    logic [6:0]    p;
    logic [57:0]   ds;

    rstn = 1'b0; TestMode = 1'b0; DataValid = 1'b0; DataIn = '0; REVData = 1'b0; ENScr = 1'b0;
    #12;
    check_eq("rst_dataout", DataOut, 0);
    check_eq("rst_framestart", FrameStart, 0);
    check_eq("rst_ready", DataReady, 0);
    check_eq("rst_cnts", {DataFrameCnt, IdleFrameCnt}, 0);

    // Basic data frame, then a reversed payload.
    do_reset(1'b0, "basic");
    send(1'b1, 30'h2AAAAAAA, 1'b0, 1'b0, 1'b0);
    grab(-1, fr, fs);
    check_eq("data_frame", fr, 32'hAAAAAAAA);
    check_eq("data_framestart", fs, 32'h80000000);
    check_eq("data_cnt1", DataFrameCnt, 1);
    send(1'b1, 30'h00000001, 1'b1, 1'b0, 1'b0);
    grab(-1, fr, fs);
    check_eq("rev_frame", fr, 32'hA0000000);
    check_eq("data_cnt2", DataFrameCnt, 2);

    // Idle insertion and counter wrap.
    do_reset(1'b0, "idle");
    for (int k = 0; k < 3; k++) begin
      send(1'b0, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0);
      grab(-1, fr, fs);
      check_eq("idle_frame", fr, 32'h40000000);
    end
    check_eq("idle_cnt3", IdleFrameCnt, 3);
    check_eq("idle_data_cnt0", DataFrameCnt, 0);
    send(1'b0, '0, 1'b0, 1'b0, 1'b0);
    grab(-1, fr, fs);
    check_eq("idle_cnt_wrap", IdleFrameCnt, 0);

    // Scrambler: zeros stay zero, then a single 1 echoes at +39 and +58.
    do_reset(1'b0, "scr");
    ds = '0;
    for (int k = 0; k < 3; k++) begin
      send(1'b1, '0, 1'b0, 1'b1, 1'b0);
      grab(-1, fr, fs);
      check_eq("scr_zero_frame", fr, 32'h80000000);
      descramble(fr, ds, pl);
    end
    send(1'b1, 30'h20000000, 1'b0, 1'b1, 1'b0);
    grab(-1, fr, fs);
    check_eq("scr_frame_a", fr, 32'hA0000000);
    descramble(fr, ds, pl);
    check_eq("descr_a", pl, 30'h20000000);
    send(1'b1, '0, 1'b0, 1'b1, 1'b0);
    grab(-1, fr, fs);
    check_eq("scr_frame_b", fr, 32'h80100002);
    descramble(fr, ds, pl);
    check_eq("descr_b", pl, 0);
    send(1'b1, '0, 1'b0, 1'b1, 1'b0);
    grab(-1, fr, fs);
    check_eq("scr_frame_c", fr, 32'h80000800);
    descramble(fr, ds, pl);
    check_eq("descr_c", pl, 0);

    // PRBS7 held from reset.
    do_reset(1'b1, "prbs");
    p = 7'h7F;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, 30'h15555555, 1'b0, 1'b0, 1'b1);
      grab(-1, fr, fs);
      if (k == 0) check_eq("prbs_first7", fr[W-1:W-7], 7'b0000001);
      prbs_frame(p, ex);
      check_eq("prbs_frame", fr, ex);
      check_eq("prbs_framestart", fs, 32'h80000000);
    end
    check_eq("prbs_cnts", {DataFrameCnt, IdleFrameCnt}, 0);

    // Mode toggles mid-frame only take effect at the next frame.
    do_reset(1'b0, "toggle");
    p = 7'h7F;
    send(1'b1, 30'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
    grab(10, fr, fs);
    check_eq("toggle_on_data", fr, 32'h8F0F0F0F);
    send(1'b1, 30'h15555555, 1'b0, 1'b0, 1'b1);
    grab(5, fr, fs);
    prbs_frame(p, ex);
    check_eq("toggle_off_prbs", fr, ex);
    check_eq("toggle_cnt", DataFrameCnt, 1);
    send(1'b1, 30'h12345678, 1'b0, 1'b0, 1'b0);
    grab(-1, fr, fs);
    check_eq("toggle_back_data", fr, 32'h92345678);
    check_eq("toggle_cnt2", DataFrameCnt, 2);

    // Reset mid-frame.
    send(1'b1, 30'h3FFFFFFF, 1'b0, 1'b0, 1'b0);
    repeat (12) begin
      @(posedge clk); @(negedge clk);
    end
    check_eq("pre_reset_out", DataOut, 1);
    rstn = 1'b0;
    #1;
    check_eq("async_rst_out", DataOut, 0);
    check_eq("async_rst_cnts", {DataFrameCnt, IdleFrameCnt}, 0);
    check_eq("async_rst_ready", DataReady, 0);
    @(negedge clk);
    rstn = 1'b1;
    begin
      int n = 0;
      while (!DataReady && n < 100) begin
        @(posedge clk); @(negedge clk);
        n++;
      end
      check_eq("reload_after_reset", n, 31);
    end
    send(1'b1, 30'h2AAAAAAA, 1'b0, 1'b0, 1'b0);
    grab(-1, fr, fs);
    check_eq("post_reset_frame", fr, 32'hAAAAAAAA);
    check_eq("post_reset_cnt", DataFrameCnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmro_serial_framer.md
Name: dmro_serial_framer

Overview:
- Parametrised successor to the diagnostic-mode readout path.
- Accepts parallel DATA_WIDTH-bit words through a valid/ready handshake and builds frames of HEADER_WIDTH+DATA_WIDTH bits (W).
- Scrambling, bit-order reversal and PRBS7 test mode are applied serially at bit rate; idle frames are inserted automatically when no data is offered.
- Runs entirely in the bit-clock domain. The word strobe and load handshake are generated internally, so no word clock input exists.

Parameters:
- DATA_WIDTH, 30: payload bits per frame (>=8).
- HEADER_WIDTH, 2: header bits per frame (>=1).
- DATA_HEADER, 2'b10: header sent with a valid data frame.
- IDLE_HEADER, 2'b01: header sent with an idle frame.
- IDLE_PATTERN, 0: DATA_WIDTH-bit payload sent in an idle frame.
- CNT_WIDTH, 16: width of the frame counters.

Ports:
- CLKBit  input  1  bit clock; all logic on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- DataIn  input  DATA_WIDTH  payload word.
- DataValid  input  1  DataIn holds a word to send.
- DataReady  output  1  high in the load cycle; a word is accepted when DataValid&DataReady.
- REVData  input  1  reverse payload bit order (bit 0 sent first after the header).
- ENScr  input  1  enable the payload scrambler.
- TestMode  input  1  output a continuous PRBS7 instead of frames.
- DataOut  output  1  serial output, registered.
- FrameStart  output  1  high while DataOut carries the first bit of a frame.
- DataFrameCnt  output  CNT_WIDTH  number of data frames sent; wraps.
- IdleFrameCnt  output  CNT_WIDTH  number of idle frames sent; wraps.

Behaviour:
- Reset (async, RSTn=0) clears the following: BitCnt=0, shift register=0, scrambler state S[57:0]=0, PRBS state P[6:0]=7'h7F, mode registers=0, DataOut=0, FrameStart=0, both counters=0. DataReady is combinational, so it is 0 because BitCnt!=W-1.
- BitCnt counts 0..W-1 every cycle and wraps. DataReady = (BitCnt==W-1).
- Load edge (edge where BitCnt==W-1):
  - TestMode, ENScr and REVData are latched into mode registers. Mode changes take effect only at frame boundaries.
  - If DataValid=1: frame = {DATA_HEADER, payload}, where payload = REVData ? bit-reverse(DataIn) : DataIn. DataFrameCnt is incremented.
  - If DataValid=0: frame = {IDLE_HEADER, IDLE_PATTERN}. IdleFrameCnt is incremented.
  - In latched test mode, neither counter changes and the input word is not accepted. DataReady still pulses; the source must ignore it while TestMode=1.
  - DataOut <= frame[W-1], shift <= frame[W-2:0], FrameStart <= 1.
- Edges between load edges: DataOut <= shift MSB, shift shifts left, FrameStart <= 0.
- Latency: a word accepted at load edge k drives DataOut from after edge k through after edge k+W-1, MSB first.
- The first frame is loaded at the W-th edge after reset release. DataOut stays 0 before that edge.
- Scrambler (latched ENScr=1, normal mode, payload bits only; headers are never scrambled):
  - Polynomial 1+x^39+x^58, multiplicative.
  - For raw bit d: out = d^S[38]^S[57], then S <= {S[56:0], out}.
  - With ENScr=0, S holds its value and payload bits pass unchanged.
  - Idle payloads are scrambled the same way as data payloads.
- Test mode (latched TestMode=1):
  - Every edge: DataOut <= P[6]^P[5], P <= {P[5:0], P[6]^P[5]}.
  - The shift register still loads and shifts but is not driven out.
  - P runs continuously across frames and is never reseeded except by reset.
  - FrameStart still marks frame boundaries.
- Counters wrap from 2^CNT_WIDTH-1 to 0.
- Simultaneous events: a DataValid change at a non-load edge has no effect. Mode inputs are sampled only at the load edge.
- Reset mid-frame aborts the frame immediately. The counters do not include the aborted frame beyond its load increment.

Test Plan:
- Defaults (W=32); release reset; DataValid=1, DataIn=30'h2AAAAAAA, ENScr=0, REVData=0 -> DataReady first high at cycle 31. From the next edge, 32 bits are output: 1,0,1,0,... repeating 10. FrameStart=1 only on the first bit. DataFrameCnt=1.
- DataIn=30'h00000001, REVData=1 -> the bit after the header "10" is 1, followed by 29 zeros.
- DataValid=0 for 3 frames -> each frame is "01" followed by 30 zeros. IdleFrameCnt=3, DataFrameCnt=0.
- ENScr=1, DataIn=0 for 3 frames after reset -> every payload bit is 0 (S stays 0). Then DataIn=30'h20000000 -> the first payload bit is 1. That 1 reappears XORed at payload-bit offsets +39 and +58, checked against a reference descrambler, which recovers the original data exactly. Headers are always unscrambled.
- TestMode=1 held from reset -> from the first load edge DataOut = 0,0,0,0,0,0,1,... The 127-bit sequence repeats and matches the x^7+x^6+1 model. Both counters stay 0.
- Toggle TestMode mid-frame, and pulse RSTn low mid-frame -> the mode switches only at the next FrameStart. Reset forces DataOut=0 and both counters to 0 asynchronously, and the first frame reloads after W edges.
